// File: rtl/regfile.sv
//------------------------------------------------------------------------------
// Module   : regfile
// Purpose  : 32 x 64-bit ARM64 register file. One synchronous write port and
//            two combinational read ports. X31 reads as zero (XZR).
// Option   : REGFILE_BYPASS_EN - same-cycle write-to-read bypass on both ports
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ps/1ps
`default_nettype none

module regfile #(
    parameter int NREG = 32,
    parameter int W    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         RegWrite,
    input  logic [4:0]   WriteRegister,
    input  logic [W-1:0] WriteData,
    input  logic [4:0]   ReadRegister1,
    input  logic [4:0]   ReadRegister2,
    output logic [W-1:0] ReadData1,
    output logic [W-1:0] ReadData2
);

    localparam int         c_NSTORE = NREG - 1;
    localparam logic [4:0] c_XZR    = 5'(NREG - 1);

    logic [W-1:0] regs_q [c_NSTORE];
    logic [W-1:0] regs_d [c_NSTORE];
    logic [c_NSTORE-1:0] w_wen;

    // Decoder outputs exist only for X0-X30; a write to X31 has nowhere to land.
    generate
        for (genvar i = 0; i < c_NSTORE; i++) begin : g_wdec
            assign w_wen[i] = RegWrite && (WriteRegister == 5'(i));
        end
    endgenerate

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < c_NSTORE; i++) begin
            if (w_wen[i]) begin
                regs_d[i] = WriteData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NSTORE; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok = RegWrite && !reset && (WriteRegister != c_XZR);
`endif

    always_comb begin
        ReadData1 = '0;
        if (ReadRegister1 != c_XZR) begin
            ReadData1 = regs_q[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
            if (w_byp_ok && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end
`endif
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadRegister2 != c_XZR) begin
            ReadData2 = regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
            if (w_byp_ok && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile
// Purpose  : Scoreboard bench for regfile (either bypass build).
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ps/1ps
`default_nettype none

module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] mdl [32];
    int          n_vec = 0;
    int          n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    regfile #(.NREG(32), .W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #50 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time budget, got %0d vectors, required completion", n_vec);
        $fatal(1);
    end

    // Inputs change 5 ps after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = '1;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            sb.push_back('{64'h0, 64'h0});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
                n_err++;
                $display("FAIL reset_sweep idx=%0d: got %h/%h, required %h/%h", i, ReadData1, ReadData2, e.e1, e.e2);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'd500;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd0;
        sb.push_back('{c_BYP ? 64'd500 : mdl[5], mdl[0]});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL write_x5_cycle: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        mdl[5] = 64'd500;
        RegWrite = 1'b0; WriteData = 64'd1234;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{mdl[5], mdl[5]});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
                n_err++;
                $display("FAIL read_x5 step=%0d: got %h/%h, required %h/%h", k, ReadData1, ReadData2, e.e1, e.e2);
            end
            tick();
        end
    endtask

    task automatic test_xzr();
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        sb.push_back('{64'h0, 64'h0});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL xzr_write_cycle: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        tick();
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            sb.push_back('{mdl[i], mdl[i]});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
                n_err++;
                $display("FAIL xzr_sweep idx=%0d: got %h/%h, required %h/%h", i, ReadData1, ReadData2, e.e1, e.e2);
            end
            tick();
        end
    endtask

    task automatic test_all_regs();
        logic [63:0] base;
        base = 64'h0101_0101_0101_0101;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        for (int i = 0; i < 31; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = base * 64'(i + 1);
            tick();
            mdl[i] = base * 64'(i + 1);
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(30 - i);
            sb.push_back('{mdl[i], mdl[30 - i]});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
                n_err++;
                $display("FAIL pair_read (%0d,%0d): got %h/%h, required %h/%h", i, 30 - i, ReadData1, ReadData2, e.e1, e.e2);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'd500;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        tick();
        mdl[7] = 64'd500;
        WriteData = 64'd1234;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        sb.push_back('{c_BYP ? 64'd1234 : mdl[7], c_BYP ? 64'd1234 : mdl[7]});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL same_cycle_x7: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        mdl[7] = 64'd1234;
        RegWrite = 1'b0;
        sb.push_back('{mdl[7], mdl[7]});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL next_cycle_x7: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        // Only port 1 matches the write target; port 2 must show stored X8.
        RegWrite = 1'b1; WriteData = 64'd555;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
        sb.push_back('{c_BYP ? 64'd555 : mdl[7], mdl[8]});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL split_port_bypass: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        ReadRegister1 = 5'd8; ReadRegister2 = 5'd7;
        sb.push_back('{mdl[8], c_BYP ? 64'd555 : mdl[7]});
        #10;
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL split_port_bypass_b: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        mdl[7] = 64'd555;
        RegWrite = 1'b0;
    endtask

    task automatic test_reset_with_write();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'd99;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd5;
        sb.push_back('{mdl[3], mdl[5]});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL reset_cycle_read: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        sb.push_back('{64'h0, 64'h0});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL reset_held_read: got %h/%h, required 0/0", ReadData1, ReadData2);
        end
        tick();
        reset = 1'b0;
        sb.push_back('{c_BYP ? 64'd99 : 64'h0, 64'h0});
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
            n_err++;
            $display("FAIL first_write_after_reset_cycle: got %h/%h, required %h/%h", ReadData1, ReadData2, e.e1, e.e2);
        end
        tick();
        mdl[3] = 64'd99;
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            sb.push_back('{mdl[i], mdl[31 - i]});
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1 || ReadData2 !== e.e2) begin
                n_err++;
                $display("FAIL post_reset_sweep idx=%0d: got %h/%h, required %h/%h", i, ReadData1, ReadData2, e.e1, e.e2);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        tick();
        test_reset();
        test_write_read();
        test_xzr();
        test_all_regs();
        test_same_cycle();
        test_reset_with_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
